// File: rtl/div.sv
// Multi-cycle 32-bit restoring divider returning {remainder, quotient} over a start/ready handshake.
// Define QUANTR_DIV_SIGNED_EN to honor signed_div_i; otherwise every divide is unsigned.
module div (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    typedef enum logic [1:0] {
        S_FREE   = 2'd0,
        S_BYZERO = 2'd1,
        S_ON     = 2'd2,
        S_END    = 2'd3
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [4:0]  r_cnt, w_cnt_nxt;
    logic [31:0] r_rem, w_rem_nxt;
    logic [31:0] r_quo, w_quo_nxt;
    logic [31:0] r_dvsr, w_dvsr_nxt;
    logic [63:0] r_result, w_result_nxt;
    logic        r_ready, w_ready_nxt;

    logic [32:0] w_upper;
    logic [33:0] w_trial;
    logic        w_ge;
    logic [31:0] w_rem_step, w_quo_step;
    logic [31:0] w_mag_a, w_mag_b;
    logic [31:0] w_rem_fin, w_quo_fin;
    logic        w_unused_trial;

    // One restoring step: shift in the next dividend bit, trial-subtract the divisor.
    assign w_upper        = {r_rem, r_quo[31]};
    assign w_trial        = {1'b0, w_upper} - {2'b00, r_dvsr};
    assign w_ge           = ~w_trial[33];
    assign w_rem_step     = w_ge ? w_trial[31:0] : w_upper[31:0];
    assign w_quo_step     = {r_quo[30:0], w_ge};
    assign w_unused_trial = w_trial[32];

`ifdef QUANTR_DIV_SIGNED_EN
    logic r_neg_q, w_neg_q_nxt;
    logic r_neg_r, w_neg_r_nxt;
    logic w_neg_a, w_neg_b;

    function automatic logic [31:0] neg32(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

    assign w_neg_a   = signed_div_i & opdata1_i[31];
    assign w_neg_b   = signed_div_i & opdata2_i[31];
    assign w_mag_a   = w_neg_a ? neg32(opdata1_i) : opdata1_i;
    assign w_mag_b   = w_neg_b ? neg32(opdata2_i) : opdata2_i;
    // Remainder follows the dividend's sign; quotient is negative when the signs differ.
    assign w_quo_fin = r_neg_q ? neg32(w_quo_step) : w_quo_step;
    assign w_rem_fin = r_neg_r ? neg32(w_rem_step) : w_rem_step;
`else
    logic w_unused_sgn;

    assign w_unused_sgn = signed_div_i;
    assign w_mag_a      = opdata1_i;
    assign w_mag_b      = opdata2_i;
    assign w_quo_fin    = w_quo_step;
    assign w_rem_fin    = w_rem_step;
`endif

    // Next-state and next-output logic for the divide handshake.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_rem_nxt    = r_rem;
        w_quo_nxt    = r_quo;
        w_dvsr_nxt   = r_dvsr;
        w_result_nxt = r_result;
        w_ready_nxt  = r_ready;
`ifdef QUANTR_DIV_SIGNED_EN
        w_neg_q_nxt  = r_neg_q;
        w_neg_r_nxt  = r_neg_r;
`endif
        case (r_state)
            S_FREE: begin
                w_result_nxt = 64'h0;
                w_ready_nxt  = 1'b0;
                if (start_i && !annul_i) begin
                    w_rem_nxt  = 32'h0;
                    w_quo_nxt  = w_mag_a;
                    w_dvsr_nxt = w_mag_b;
                    w_cnt_nxt  = 5'd0;
`ifdef QUANTR_DIV_SIGNED_EN
                    w_neg_q_nxt = w_neg_a ^ w_neg_b;
                    w_neg_r_nxt = w_neg_a;
`endif
                    if (opdata2_i == 32'h0) begin
                        w_state_nxt = S_BYZERO;
                    end else begin
                        w_state_nxt = S_ON;
                    end
                end else begin
                    w_state_nxt = S_FREE;
                end
            end
            S_BYZERO: begin
                w_state_nxt  = S_END;
                w_result_nxt = 64'h0;
                w_ready_nxt  = 1'b1;
            end
            S_ON: begin
                if (annul_i) begin
                    w_state_nxt  = S_FREE;
                    w_result_nxt = 64'h0;
                    w_ready_nxt  = 1'b0;
                end else begin
                    w_rem_nxt = w_rem_step;
                    w_quo_nxt = w_quo_step;
                    w_cnt_nxt = r_cnt + 5'd1;
                    if (r_cnt == 5'd31) begin
                        w_state_nxt  = S_END;
                        w_result_nxt = {w_rem_fin, w_quo_fin};
                        w_ready_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = S_ON;
                    end
                end
            end
            S_END: begin
                if (start_i) begin
                    w_state_nxt = S_END;
                end else begin
                    w_state_nxt  = S_FREE;
                    w_result_nxt = 64'h0;
                    w_ready_nxt  = 1'b0;
                end
            end
            default: begin
                w_state_nxt  = S_FREE;
                w_result_nxt = 64'h0;
                w_ready_nxt  = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_FREE;
            r_cnt    <= 5'd0;
            r_rem    <= 32'h0;
            r_quo    <= 32'h0;
            r_dvsr   <= 32'h0;
            r_result <= 64'h0;
            r_ready  <= 1'b0;
`ifdef QUANTR_DIV_SIGNED_EN
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_rem    <= w_rem_nxt;
            r_quo    <= w_quo_nxt;
            r_dvsr   <= w_dvsr_nxt;
            r_result <= w_result_nxt;
            r_ready  <= w_ready_nxt;
`ifdef QUANTR_DIV_SIGNED_EN
            r_neg_q  <= w_neg_q_nxt;
            r_neg_r  <= w_neg_r_nxt;
`endif
        end
    end

    assign result_o = r_result;
    assign ready_o  = r_ready;

endmodule
